uart_rx_debug: RTL

- UART receiver (8N1 by default) for the host-to-CPU direction of the debug link; the CPU top already drives o_tx.
- Deserialises the host's byte stream into parallel bytes with a one-cycle valid strobe.
- Feeds the debug unit's command/instruction-load logic.
- Contains its own 16x oversampling tick generator, so it needs only the system clock (the clock-wizard output).

---
 rtl/uart_rx_debug.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_debug.sv
// uart_rx_debug: 8N1 UART receiver for the host-to-CPU debug link, with its own
// oversampling tick generator. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_debug #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned BAUD_DIV   = 27,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_parity_err,
  output logic               o_busy
);

  localparam int unsigned BW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned SMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int unsigned SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int unsigned NW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT     = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, rx_s;
  logic [BW-1:0]        baud_q;
  logic                 tick;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NB_DATA-1:0]   sh_q, sh_d;
  logic [NB_DATA-1:0]   data_d;
  logic                 done_d, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_d;
`endif

  // Two-flop synchroniser; idle line is high so both flops reset to 1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      rx_s    <= sync1_q;
    end
  end

  // Free-running oversampling tick; deliberately not re-phased on a start edge.
  assign tick = (baud_q == BAUD_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      baud_q <= '0;
    end else if (tick) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_q + 1'b1;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    data_d  = o_data;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
          n_d     = '0;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d  = '0;
            sh_d = {rx_s, sh_q[NB_DATA-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == S_BIT) begin
            s_d       = '0;
            par_bad_d = ^{sh_q, rx_s};
            state_d   = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                perr_d = 1'b1;
              end else begin
                data_d = sh_q;
                done_d = 1'b1;
              end
`else
              data_d = sh_q;
              done_d = 1'b1;
`endif
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      s_q         <= '0;
      n_q         <= '0;
      sh_q        <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      sh_q        <= sh_d;
      o_data      <= data_d;
      o_rx_done   <= done_d;
      o_frame_err <= ferr_d;
      o_busy      <= (state_d != IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      par_bad_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      o_parity_err <= perr_d;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
